// File: rtl/md5_block_feeder.sv
// MD5 front end: packs a little-endian word stream into padded 512-bit blocks,
// drives the external round pipeline and folds its results into the final digest.
module md5_block_feeder #(
  parameter int CORE_LAT = 111,
  parameter int LEN_W    = 32
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  input  logic [31:0]  s_data_i,
  input  logic         s_last_i,
  input  logic [2:0]   s_bytes_i,
  output logic [511:0] wb_o,
  output logic [31:0]  a_o,
  output logic [31:0]  b_o,
  output logic [31:0]  c_o,
  output logic [31:0]  d_o,
  output logic         blk_valid_o,
  input  logic [31:0]  core_a_i,
  input  logic [31:0]  core_b_i,
  input  logic [31:0]  core_c_i,
  input  logic [31:0]  core_d_i,
  output logic [127:0] digest_o,
  output logic         digest_valid_o
);

  localparam int          WAIT_W = $clog2(CORE_LAT + 1);
  localparam logic [31:0] IV_A   = 32'h67452301;
  localparam logic [31:0] IV_B   = 32'hefcdab89;
  localparam logic [31:0] IV_C   = 32'h98badcfe;
  localparam logic [31:0] IV_D   = 32'h10325476;

  typedef enum logic [2:0] {
    ST_FILL  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_PAD   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t             state_q;
  logic [3:0]         idx_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [511:0]       buf_q;
  logic               final_q;
  logic               pad_pending_q;
  logic               marker_placed_q;
  logic [31:0]        ha_q, hb_q, hc_q, hd_q;
  logic [WAIT_W-1:0]  wait_q;
  logic               s_ready_q;
  logic               blk_valid_q;
  logic [511:0]       wb_q;
  logic [31:0]        a_q, b_q, c_q, d_q;
  logic [127:0]       digest_q;
  logic               digest_valid_q;

  logic [2:0]         bytes_d;
  logic [31:0]        masked_d;
  logic [LEN_W-1:0]   cnt_next_d;
  logic [4:0]         mark_idx_d;
  logic               len_here_d;
  logic [63:0]        bitlen_d;
  logic [63:0]        pad_len_d;
  logic [511:0]       fill_blk_d;
  logic [511:0]       pad_blk_d;
  logic [31:0]        sa_d, sb_d, sc_d, sd_d;

  // Assemble the outgoing block from buffered words plus the word being accepted
  always_comb begin
    bytes_d    = (s_last_i && (s_bytes_i < 3'd4)) ? s_bytes_i : 3'd4;
    masked_d   = 32'h0000_0000;
    for (int b = 0; b < 4; b++) begin
      if (3'(b) < bytes_d) begin
        masked_d[8*b +: 8] = s_data_i[8*b +: 8];
      end else if (3'(b) == bytes_d) begin
        masked_d[8*b +: 8] = 8'h80;
      end else begin
        masked_d[8*b +: 8] = 8'h00;
      end
    end
    cnt_next_d = cnt_q + LEN_W'(bytes_d);
    // A full final word pushes the 0x80 marker into the following word slot
    mark_idx_d = {1'b0, idx_q} + ((bytes_d == 3'd4) ? 5'd1 : 5'd0);
    len_here_d = s_last_i && (mark_idx_d <= 5'd13);
    bitlen_d   = 64'(cnt_next_d) << 3'd3;
    pad_len_d  = 64'(cnt_q) << 3'd3;
    fill_blk_d = '0;
    for (int i = 0; i < 16; i++) begin
      if (len_here_d && (i == 14)) begin
        fill_blk_d[32*i +: 32] = bitlen_d[31:0];
      end else if (len_here_d && (i == 15)) begin
        fill_blk_d[32*i +: 32] = bitlen_d[63:32];
      end else if (4'(i) < idx_q) begin
        fill_blk_d[32*i +: 32] = buf_q[32*i +: 32];
      end else if (4'(i) == idx_q) begin
        fill_blk_d[32*i +: 32] = s_last_i ? masked_d : s_data_i;
      end else if (s_last_i && (bytes_d == 3'd4) && (5'(i) == mark_idx_d)) begin
        fill_blk_d[32*i +: 32] = 32'h0000_0080;
      end else begin
        fill_blk_d[32*i +: 32] = 32'h0000_0000;
      end
    end
    pad_blk_d          = '0;
    pad_blk_d[31:0]    = marker_placed_q ? 32'h0000_0000 : 32'h0000_0080;
    pad_blk_d[479:448] = pad_len_d[31:0];
    pad_blk_d[511:480] = pad_len_d[63:32];
    sa_d = ha_q + core_a_i;
    sb_d = hb_q + core_b_i;
    sc_d = hc_q + core_c_i;
    sd_d = hd_q + core_d_i;
  end

  // Control FSM with all outputs registered
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q         <= ST_FILL;
      idx_q           <= 4'd0;
      cnt_q           <= '0;
      buf_q           <= '0;
      final_q         <= 1'b0;
      pad_pending_q   <= 1'b0;
      marker_placed_q <= 1'b0;
      ha_q            <= IV_A;
      hb_q            <= IV_B;
      hc_q            <= IV_C;
      hd_q            <= IV_D;
      wait_q          <= '0;
      s_ready_q       <= 1'b1;
      blk_valid_q     <= 1'b0;
      wb_q            <= '0;
      a_q             <= IV_A;
      b_q             <= IV_B;
      c_q             <= IV_C;
      d_q             <= IV_D;
      digest_q        <= '0;
      digest_valid_q  <= 1'b0;
    end else begin
      blk_valid_q    <= 1'b0;
      digest_valid_q <= 1'b0;
      case (state_q)
        ST_FILL: begin
          if (s_valid_i && s_ready_q) begin
            buf_q[{idx_q, 5'd0} +: 32] <= s_data_i;
            cnt_q <= cnt_next_d;
            if (s_last_i || (idx_q == 4'd15)) begin
              state_q         <= ST_ISSUE;
              s_ready_q       <= 1'b0;
              blk_valid_q     <= 1'b1;
              wb_q            <= fill_blk_d;
              a_q             <= ha_q;
              b_q             <= hb_q;
              c_q             <= hc_q;
              d_q             <= hd_q;
              idx_q           <= 4'd0;
              final_q         <= len_here_d;
              pad_pending_q   <= s_last_i && !len_here_d;
              marker_placed_q <= s_last_i && (mark_idx_d <= 5'd15);
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end else begin
            s_ready_q <= 1'b1;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT;
          wait_q  <= WAIT_W'(1);
        end
        ST_WAIT: begin
          if (wait_q == WAIT_W'(CORE_LAT)) begin
            ha_q <= sa_d;
            hb_q <= sb_d;
            hc_q <= sc_d;
            hd_q <= sd_d;
            a_q  <= sa_d;
            b_q  <= sb_d;
            c_q  <= sc_d;
            d_q  <= sd_d;
            wait_q <= '0;
            if (pad_pending_q) begin
              state_q <= ST_PAD;
            end else if (final_q) begin
              state_q        <= ST_DONE;
              digest_q       <= {sd_d, sc_d, sb_d, sa_d};
              digest_valid_q <= 1'b1;
            end else begin
              state_q   <= ST_FILL;
              s_ready_q <= 1'b1;
              idx_q     <= 4'd0;
            end
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        ST_PAD: begin
          state_q         <= ST_ISSUE;
          blk_valid_q     <= 1'b1;
          wb_q            <= pad_blk_d;
          a_q             <= ha_q;
          b_q             <= hb_q;
          c_q             <= hc_q;
          d_q             <= hd_q;
          pad_pending_q   <= 1'b0;
          final_q         <= 1'b1;
          marker_placed_q <= 1'b1;
        end
        ST_DONE: begin
          state_q   <= ST_FILL;
          s_ready_q <= 1'b1;
          idx_q     <= 4'd0;
          cnt_q     <= '0;
          final_q   <= 1'b0;
          ha_q      <= IV_A;
          hb_q      <= IV_B;
          hc_q      <= IV_C;
          hd_q      <= IV_D;
        end
        default: begin
          state_q   <= ST_FILL;
          s_ready_q <= 1'b1;
          idx_q     <= 4'd0;
        end
      endcase
    end
  end

  assign s_ready_o      = s_ready_q;
  assign wb_o           = wb_q;
  assign a_o            = a_q;
  assign b_o            = b_q;
  assign c_o            = c_q;
  assign d_o            = d_q;
  assign blk_valid_o    = blk_valid_q;
  assign digest_o       = digest_q;
  assign digest_valid_o = digest_valid_q;

endmodule

// File: tb/tb_md5_block_feeder.sv
// Bench for md5_block_feeder: a behavioural MD5 round pipeline answers each block,
// and a scoreboard checks every issued block, chaining value and digest.
module tb_md5_block_feeder;

  localparam int CORE_LAT = 111;
  localparam logic [127:0] DIG_EMPTY = 128'h7e42f8ec980980e904b2008fd98c1dd4;
  localparam logic [127:0] DIG_ABC   = 128'h727fe1287d3f96d6b04fd23c98500190;
  localparam logic [127:0] IV        = 128'h10325476_98badcfe_efcdab89_67452301;

  localparam logic [31:0] K_TAB [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391};
  localparam int S_TAB [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_valid = 1'b0, s_ready, s_last = 1'b0;
  logic [31:0] s_data = 32'h0;
  logic [2:0] s_bytes = 3'd0;
  logic [511:0] wb;
  logic [31:0] a_o, b_o, c_o, d_o;
  logic blk_valid, digest_valid;
  logic [31:0] core_a = 32'h0, core_b = 32'h0, core_c = 32'h0, core_d = 32'h0;
  logic [127:0] digest;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int blk_n = 0;
  int dig_n = 0;
  logic [511:0] blk_log [0:63];
  int blk_cyc [0:63];
  logic prev_bv = 1'b0;
  logic [511:0] exp_blk_q [$];
  logic [127:0] exp_ch_q [$];
  logic [127:0] exp_dig_q [$];
  byte unsigned msg_b [0:255];
  logic [127:0] core_res = '0;
  int core_cnt = 0;
  logic core_busy = 1'b0;

  md5_block_feeder #(.CORE_LAT(CORE_LAT), .LEN_W(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .s_data_i(s_data), .s_last_i(s_last), .s_bytes_i(s_bytes), .wb_o(wb),
    .a_o(a_o), .b_o(b_o), .c_o(c_o), .d_o(d_o), .blk_valid_o(blk_valid),
    .core_a_i(core_a), .core_b_i(core_b), .core_c_i(core_c), .core_d_i(core_d),
    .digest_o(digest), .digest_valid_o(digest_valid));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 64 MD5 rounds without the final feed-forward add; returns {d,c,b,a}
  function automatic logic [127:0] md5_rounds(input logic [511:0] blk,
                                              input logic [31:0] ia, ib, ic, id);
    logic [31:0] a, b, c, d, f, t;
    int g, s;
    a = ia; b = ib; c = ic; d = id;
    for (int i = 0; i < 64; i++) begin
      if (i < 16) begin f = (b & c) | (~b & d); g = i; end
      else if (i < 32) begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
      else if (i < 48) begin f = b ^ c ^ d; g = (3 * i + 5) % 16; end
      else begin f = c ^ (b | ~d); g = (7 * i) % 16; end
      t = f + a + K_TAB[i] + blk[32*g +: 32];
      s = S_TAB[(i / 16) * 4 + (i % 4)];
      a = d; d = c; c = b;
      b = b + ((t << s) | (t >> (32 - s)));
    end
    return {d, c, b, a};
  endfunction

  // Stand-in for the round pipeline: answers exactly CORE_LAT cycles after BLK_VALID
  always @(negedge clk) begin
    if (blk_valid) begin
      core_res = md5_rounds(wb, a_o, b_o, c_o, d_o);
      core_cnt = 0;
      core_busy = 1'b1;
    end else if (core_busy) begin
      core_cnt = core_cnt + 1;
    end
    if (core_busy && core_cnt == CORE_LAT) begin
      {core_d, core_c, core_b, core_a} = core_res;
      core_busy = 1'b0;
    end else begin
      core_a = 32'hdead0000 ^ 32'(core_cnt);
      core_b = 32'hbeef0000 ^ 32'(core_cnt);
      core_c = 32'hcafe0000 ^ 32'(core_cnt);
      core_d = 32'hf00d0000 ^ 32'(core_cnt);
    end
  end

  // Scoreboard monitor for issued blocks and digests
  always @(negedge clk) begin
    logic [511:0] eb;
    logic [127:0] ec;
    if (rst_n) begin
      if (blk_valid) begin
        checks++;
        if (prev_bv) begin errors++; $display("FAIL blk_pulse: BLK_VALID high %0d cycles, want 1", 2); end
        if (blk_n < 64) begin blk_log[blk_n] = wb; blk_cyc[blk_n] = cyc; end
        blk_n++;
        checks++;
        if (exp_blk_q.size() == 0) begin
          errors++; $display("FAIL blk_unexpected: got block %h, want none", wb[63:0]);
        end else begin
          eb = exp_blk_q.pop_front();
          ec = exp_ch_q.pop_front();
          if (wb !== eb) begin errors++; $display("FAIL blk_data: got w0=%h w14=%h, want w0=%h w14=%h", wb[31:0], wb[479:448], eb[31:0], eb[479:448]); end
          checks++;
          if ({d_o, c_o, b_o, a_o} !== ec) begin errors++; $display("FAIL blk_chain: got %h, want %h", {d_o, c_o, b_o, a_o}, ec); end
        end
      end
      if (digest_valid) begin
        dig_n++;
        checks++;
        if (exp_dig_q.size() == 0) begin
          errors++; $display("FAIL dig_unexpected: got %h, want none", digest);
        end else begin
          ec = exp_dig_q.pop_front();
          if (digest !== ec) begin errors++; $display("FAIL dig_value: got %h, want %h", digest, ec); end
        end
      end
    end
    prev_bv = blk_valid;
  end

  task automatic fill_pattern(input int n, input int seed);
    for (int i = 0; i < n; i++) msg_b[i] = 8'((seed * 31 + i * 17 + 5) & 255);
  endtask

  // Byte-level reference: pad, split into blocks and push expectations
  task automatic push_expect(input int n);
    byte unsigned pb [0:191];
    int plen;
    logic [63:0] bl;
    logic [511:0] blk;
    logic [31:0] ha, hb, hc, hd;
    logic [127:0] r;
    plen = ((n + 8) / 64 + 1) * 64;
    for (int i = 0; i < plen; i++) pb[i] = (i < n) ? msg_b[i] : 8'h00;
    pb[n] = 8'h80;
    bl = 64'(n) * 64'd8;
    for (int j = 0; j < 8; j++) pb[plen - 8 + j] = bl[8*j +: 8];
    {hd, hc, hb, ha} = IV;
    for (int k = 0; k < plen / 64; k++) begin
      for (int w = 0; w < 16; w++)
        blk[32*w +: 32] = {pb[64*k+4*w+3], pb[64*k+4*w+2], pb[64*k+4*w+1], pb[64*k+4*w]};
      exp_blk_q.push_back(blk);
      exp_ch_q.push_back({hd, hc, hb, ha});
      r = md5_rounds(blk, ha, hb, hc, hd);
      ha += r[31:0]; hb += r[63:32]; hc += r[95:64]; hd += r[127:96];
    end
    exp_dig_q.push_back({hd, hc, hb, ha});
  endtask

  // Stream msg_b[0:n-1] as words; stall0 = cycles the first word waited
  task automatic send_msg(input int n, output int stall0);
    int nw, lb, stall;
    nw = (n == 0) ? 1 : (n + 3) / 4;
    stall0 = 0;
    for (int w = 0; w < nw; w++) begin
      lb = (w == nw - 1) ? n - 4 * w : 4;
      for (int b = 0; b < 4; b++) s_data[8*b +: 8] = (b < lb) ? msg_b[4*w+b] : ((n == 0) ? 8'h00 : 8'h5a);
      s_valid = 1'b1;
      s_last = (w == nw - 1);
      s_bytes = s_last ? 3'(lb) : 3'd6;
      stall = 0;
      while (!s_ready && stall < 1000) begin @(negedge clk); stall++; end
      if (w == 0) stall0 = stall;
      if (stall >= 1000) begin
        checks++; errors++;
        $display("FAIL send_timeout: word %0d not accepted, want accept within 1000", w);
        break;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic wait_digests(input int target);
    int t = 0;
    while (dig_n < target && t < 4000) begin @(negedge clk); t++; end
    if (dig_n < target) begin
      checks++; errors++;
      $display("FAIL dig_timeout: got %0d digests, want %0d", dig_n, target);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b, want 1", s_ready); end
    checks++; if (blk_valid !== 1'b0) begin errors++; $display("FAIL rst_blk_valid: got %b, want 0", blk_valid); end
    checks++; if (digest_valid !== 1'b0) begin errors++; $display("FAIL rst_dig_valid: got %b, want 0", digest_valid); end
    checks++; if (wb !== 512'h0) begin errors++; $display("FAIL rst_wb: got %h, want 0", wb[63:0]); end
    checks++; if (digest !== 128'h0) begin errors++; $display("FAIL rst_digest: got %h, want 0", digest); end
    checks++; if ({d_o, c_o, b_o, a_o} !== IV) begin errors++; $display("FAIL rst_chain: got %h, want %h", {d_o, c_o, b_o, a_o}, IV); end
  endtask

  task automatic test_empty;
    int st, base, d0;
    logic [511:0] blk;
    base = blk_n; d0 = dig_n;
    push_expect(0);
    send_msg(0, st);
    wait_digests(d0 + 1);
    blk = blk_log[base];
    checks++; if (blk[31:0] !== 32'h0000_0080) begin errors++; $display("FAIL empty_w0: got %h, want 00000080", blk[31:0]); end
    checks++; if (blk_n !== base + 1) begin errors++; $display("FAIL empty_nblk: got %0d, want 1", blk_n - base); end
    checks++; if (digest !== DIG_EMPTY) begin errors++; $display("FAIL empty_digest: got %h, want %h", digest, DIG_EMPTY); end
  endtask

  task automatic test_abc;
    int st, base, d0;
    logic [511:0] blk;
    base = blk_n; d0 = dig_n;
    msg_b[0] = 8'h61; msg_b[1] = 8'h62; msg_b[2] = 8'h63;
    push_expect(3);
    send_msg(3, st);
    wait_digests(d0 + 1);
    blk = blk_log[base];
    checks++; if (blk[31:0] !== 32'h8063_6261) begin errors++; $display("FAIL abc_w0: got %h, want 80636261", blk[31:0]); end
    checks++; if (blk[479:448] !== 32'h0000_0018) begin errors++; $display("FAIL abc_w14: got %h, want 00000018", blk[479:448]); end
    checks++; if (digest !== DIG_ABC) begin errors++; $display("FAIL abc_digest: got %h, want %h", digest, DIG_ABC); end
  endtask

  task automatic test_56;
    int st, base, d0;
    logic [511:0] b1, b2;
    base = blk_n; d0 = dig_n;
    fill_pattern(56, 3);
    push_expect(56);
    send_msg(56, st);
    wait_digests(d0 + 1);
    b1 = blk_log[base]; b2 = blk_log[base + 1];
    checks++; if (blk_n !== base + 2) begin errors++; $display("FAIL m56_nblk: got %0d, want 2", blk_n - base); end
    checks++; if (b1[479:448] !== 32'h0000_0080) begin errors++; $display("FAIL m56_b1w14: got %h, want 00000080", b1[479:448]); end
    checks++; if (b2[31:0] !== 32'h0) begin errors++; $display("FAIL m56_b2w0: got %h, want 00000000", b2[31:0]); end
    checks++; if (b2[479:448] !== 32'h0000_01c0) begin errors++; $display("FAIL m56_b2w14: got %h, want 000001c0", b2[479:448]); end
    checks++;
    if (blk_cyc[base + 1] - blk_cyc[base] !== CORE_LAT + 2) begin
      errors++; $display("FAIL m56_gap: got %0d, want %0d", blk_cyc[base + 1] - blk_cyc[base], CORE_LAT + 2);
    end
  endtask

  task automatic test_64;
    int st, base, d0;
    logic [511:0] b1, b2;
    base = blk_n; d0 = dig_n;
    fill_pattern(64, 9);
    push_expect(64);
    send_msg(64, st);
    wait_digests(d0 + 1);
    b1 = blk_log[base]; b2 = blk_log[base + 1];
    checks++; if (b1[511:480] !== {msg_b[63], msg_b[62], msg_b[61], msg_b[60]}) begin errors++; $display("FAIL m64_b1w15: got %h, want raw data", b1[511:480]); end
    checks++; if (b2[31:0] !== 32'h0000_0080) begin errors++; $display("FAIL m64_b2w0: got %h, want 00000080", b2[31:0]); end
    checks++; if (b2[479:448] !== 32'h0000_0200) begin errors++; $display("FAIL m64_b2w14: got %h, want 00000200", b2[479:448]); end
  endtask

  task automatic test_reset_in_wait;
    int st, b0, d0, t;
    b0 = blk_n; d0 = dig_n; t = 0;
    msg_b[0] = 8'h61; msg_b[1] = 8'h62; msg_b[2] = 8'h63;
    push_expect(3);
    send_msg(3, st);
    while (blk_n == b0 && t < 500) begin @(negedge clk); t++; end
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    exp_dig_q.delete();
    @(negedge clk);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rw_ready: got %b, want 1", s_ready); end
    checks++; if (blk_valid !== 1'b0) begin errors++; $display("FAIL rw_blk_valid: got %b, want 0", blk_valid); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (CORE_LAT + 20) @(negedge clk);
    checks++; if (dig_n !== d0) begin errors++; $display("FAIL rw_stale_digest: got %0d digests, want 0", dig_n - d0); end
    checks++; if (blk_n !== b0 + 1) begin errors++; $display("FAIL rw_stale_blk: got %0d blocks, want 1", blk_n - b0); end
    push_expect(3);
    send_msg(3, st);
    wait_digests(d0 + 1);
    checks++; if (digest !== DIG_ABC) begin errors++; $display("FAIL rw_abc_digest: got %h, want %h", digest, DIG_ABC); end
  endtask

  task automatic test_back_to_back;
    int st, d0;
    d0 = dig_n;
    fill_pattern(20, 1);
    push_expect(20);
    send_msg(20, st);
    fill_pattern(60, 2);
    push_expect(60);
    send_msg(60, st);
    checks++; if (st !== CORE_LAT + 2) begin errors++; $display("FAIL b2b_stall1: got %0d, want %0d", st, CORE_LAT + 2); end
    fill_pattern(62, 4);
    push_expect(62);
    send_msg(62, st);
    checks++; if (st !== 2 * CORE_LAT + 4) begin errors++; $display("FAIL b2b_stall2: got %0d, want %0d", st, 2 * CORE_LAT + 4); end
    wait_digests(d0 + 3);
    checks++; if (exp_blk_q.size() !== 0) begin errors++; $display("FAIL b2b_pending: got %0d blocks outstanding, want 0", exp_blk_q.size()); end
  endtask

  initial begin
    test_reset;
    test_empty;
    test_abc;
    test_56;
    test_64;
    test_reset_in_wait;
    test_back_to_back;
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
